// File: rtl/config_pkg.sv
// Shared definitions for the fpga_250 configuration loader: FSM state
// encodings and the default word/chain geometry of the fabric.
package config_pkg;

  localparam int unsigned WORD_W_DEFAULT    = 32;
  localparam int unsigned CHAIN_LEN_DEFAULT = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/cfg_piso.sv
// Parallel-load, serial-out shift register; bit 0 leaves first.
module cfg_piso #(
  parameter int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] d,
  output logic              q0
);

  logic [WORD_W-1:0] r_shreg;

  // A load takes priority so a back-to-back word replaces the spent one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (load) begin
      r_shreg <= d;
    end else if (shift) begin
      r_shreg <= r_shreg >> 1;
    end
  end

  assign q0 = r_shreg[0];

endmodule

// File: rtl/config_loader.sv
// Serial configuration loader: accepts words over valid/ready and shifts
// exactly CHAIN_LEN bits LSB-first onto the fabric configuration chain.
module config_loader
  import config_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEFAULT,
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_bit,
  output logic              cfg_en,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WL_W = $clog2(WORD_W + 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_bits_left;
  logic [WL_W-1:0]  r_word_left;
  logic             r_done;

  logic             w_ready;
  logic             w_accept;
  logic             w_word_end;
  logic             w_final;
  logic             w_shifting;
  logic             w_q0;
  logic [CNT_W-1:0] w_bits_after;
  logic [WL_W-1:0]  w_word_len;

  assign w_shifting = (r_state == ST_SHIFT);
  assign w_word_end = (r_word_left == WL_W'(1));
  assign w_final    = w_word_end && (r_bits_left == CNT_W'(1));
  assign w_accept   = w_ready && word_valid;

  // A word accepted during SHIFT replaces the one whose last bit goes out
  // this cycle, so its length is taken from the already-decremented count.
  assign w_bits_after = w_shifting ? (r_bits_left - CNT_W'(1)) : r_bits_left;
  assign w_word_len   = (32'(w_bits_after) >= WORD_W) ? WL_W'(WORD_W)
                                                      : WL_W'(w_bits_after);

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        w_ready = !abort;
        if (abort)           w_state_next = ST_IDLE;
        else if (word_valid) w_state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_ready = w_word_end && !w_final && !abort;
        if (abort || w_final) w_state_next = ST_IDLE;
        else if (w_word_end)  w_state_next = word_valid ? ST_SHIFT : ST_LOAD;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_bits_left <= '0;
      r_word_left <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && start && !abort) begin
        r_bits_left <= CNT_W'(CHAIN_LEN);
        r_done      <= 1'b0;
      end
      if (abort) r_done <= 1'b0;
      if (w_shifting && !abort) begin
        r_bits_left <= r_bits_left - CNT_W'(1);
        r_word_left <= r_word_left - WL_W'(1);
        if (w_final) r_done <= 1'b1;
      end
      if (w_accept) r_word_left <= w_word_len;
    end
  end

  cfg_piso #(
    .WORD_W(WORD_W)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (w_accept),
    .shift(w_shifting),
    .d    (word_data),
    .q0   (w_q0)
  );

  assign word_ready = w_ready;
  assign cfg_en     = w_shifting;
  assign cfg_bit    = w_shifting && w_q0;
  assign busy       = (r_state != ST_IDLE);
  assign done       = r_done;

endmodule

// File: tb/tb_config_loader.sv
// Directed bench for config_loader with WORD_W=8, CHAIN_LEN=20.
module tb_config_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] word_data = '0;
  logic       word_valid = 1'b0;
  logic       word_ready, cfg_bit, cfg_en, busy, done;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap;
  int ncap, first_en, last_en, done_k, busy_low_k, abort_k, post_abort_bad;

  config_loader #(
    .WORD_W   (8),
    .CHAIN_LEN(20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .cfg_bit   (cfg_bit),
    .cfg_en    (cfg_en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Drives one load; k counts cycles after the accepted start (k=1 is LOAD).
  // abort_n/start_n: pulse abort/start in the cycle of the n-th cfg_en (0=never).
  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int gap,
                          input int abort_n, input int start_n);
    logic [7:0] words [3];
    int widx, gapl, nen;
    words[0] = w0; words[1] = w1; words[2] = w2;
    widx = 0; gapl = 0; nen = 0;
    cap = '0; ncap = 0; first_en = -1; last_en = -1; done_k = -1;
    busy_low_k = -1; abort_k = -1; post_abort_bad = 0;
    @(negedge clk);
    start = 1'b1; abort = 1'b0; word_valid = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      if (cfg_en) begin
        if (ncap < 32) cap[ncap] = cfg_bit;
        ncap++; nen++;
        if (first_en < 0) first_en = k;
        last_en = k;
      end
      if (!busy && busy_low_k < 0) busy_low_k = k;
      if (abort_k >= 0 && k > abort_k && (cfg_en || busy || done)) post_abort_bad++;
      if (done) begin done_k = k; break; end
      if (abort_k >= 0 && k >= abort_k + 2) break;
      if (cfg_en && nen == abort_n) begin abort = 1'b1; abort_k = k; end
      if (cfg_en && nen == start_n) start = 1'b1;
      if (gapl > 0) begin
        word_valid = 1'b0; gapl--;
      end else begin
        word_valid = (widx < 3);
        if (widx < 3) word_data = words[widx];
      end
      #1;
      if (word_valid && word_ready) begin
        widx++;
        if (widx == 1) gapl = gap;
      end
    end
    start = 1'b0; abort = 1'b0; word_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({word_ready, cfg_bit, cfg_en, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 00000", {word_ready, cfg_bit, cfg_en, busy, done});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_streaming();
    run_load(8'hA5, 8'h3C, 8'hFF, 0, 0, 0);
    checks++;
    if (cap !== 32'h000F3CA5) begin errors++; $display("FAIL stream_bits: got %h expected 000f3ca5", cap); end
    checks++;
    if (ncap !== 20) begin errors++; $display("FAIL stream_count: got %0d expected 20", ncap); end
    checks++;
    if (first_en !== 2 || last_en !== 21) begin
      errors++; $display("FAIL stream_window: got %0d..%0d expected 2..21", first_en, last_en);
    end
    checks++;
    if (done_k !== 22) begin errors++; $display("FAIL stream_done: got %0d expected 22", done_k); end
    checks++;
    if (busy_low_k !== 22) begin errors++; $display("FAIL stream_busy: got %0d expected 22", busy_low_k); end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL done_hold: got done=%b busy=%b expected 1 0", done, busy);
    end
  endtask

  task automatic test_partial_word();
    run_load(8'hA5, 8'h3C, 8'h0F, 0, 0, 0);
    checks++;
    if (cap !== 32'h000F3CA5 || ncap !== 20) begin
      errors++; $display("FAIL partial_bits: got %h/%0d expected 000f3ca5/20", cap, ncap);
    end
    checks++;
    if (done_k !== 22) begin errors++; $display("FAIL partial_done: got %0d expected 22", done_k); end
  endtask

  task automatic test_backpressure();
    run_load(8'hA5, 8'h3C, 8'hFF, 11, 0, 0);
    checks++;
    if (cap !== 32'h000F3CA5 || ncap !== 20) begin
      errors++; $display("FAIL bp_bits: got %h/%0d expected 000f3ca5/20", cap, ncap);
    end
    checks++;
    if (last_en - first_en + 1 - ncap !== 4) begin
      errors++; $display("FAIL bp_gap: got %0d expected 4", last_en - first_en + 1 - ncap);
    end
    checks++;
    if (done_k !== 26) begin errors++; $display("FAIL bp_done: got %0d expected 26", done_k); end
  endtask

  task automatic test_abort_and_start_busy();
    run_load(8'hA5, 8'h3C, 8'hFF, 0, 0, 3);
    checks++;
    if (ncap !== 20 || done_k !== 22) begin
      errors++; $display("FAIL start_busy: got %0d bits done@%0d expected 20 bits done@22", ncap, done_k);
    end
    run_load(8'hA5, 8'h3C, 8'hFF, 0, 5, 0);
    checks++;
    if (ncap !== 5 || cap !== 32'h05) begin
      errors++; $display("FAIL abort_bits: got %h/%0d expected 05/5", cap, ncap);
    end
    checks++;
    if (post_abort_bad !== 0 || abort_k !== 6) begin
      errors++; $display("FAIL abort_quiet: got %0d active cycles at abort %0d expected 0 at 6", post_abort_bad, abort_k);
    end
    checks++;
    if (done_k !== -1 || done !== 1'b0) begin
      errors++; $display("FAIL abort_done: got %0d/%b expected -1/0", done_k, done);
    end
    // Abort in LOAD with a word on offer: not accepted, nothing shifted.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; word_valid = 1'b1; word_data = 8'hFF; abort = 1'b1;
    #1;
    checks++;
    if (word_ready !== 1'b0) begin errors++; $display("FAIL abort_load_ready: got %b expected 0", word_ready); end
    @(negedge clk); abort = 1'b0; word_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || cfg_en !== 1'b0) begin
      errors++; $display("FAIL abort_load_idle: got busy=%b en=%b expected 0 0", busy, cfg_en);
    end
  endtask

  task automatic test_reset_mid_load();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; word_valid = 1'b1; word_data = 8'hA5;
    @(negedge clk); word_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cfg_en !== 1'b1 || cfg_bit !== 1'b1) begin
      errors++; $display("FAIL mid_load_active: got en=%b bit=%b expected 1 1", cfg_en, cfg_bit);
    end
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if ({word_ready, cfg_bit, cfg_en, busy, done} !== 5'b0) begin
      errors++; $display("FAIL mid_load_reset: got %b expected 00000", {word_ready, cfg_bit, cfg_en, busy, done});
    end
    run_load(8'h5A, 8'hC3, 8'h09, 0, 0, 0);
    checks++;
    if (cap !== 32'h0009C35A || ncap !== 20 || done_k !== 22) begin
      errors++; $display("FAIL reload_after_reset: got %h/%0d done@%0d expected 0009c35a/20 done@22", cap, ncap, done_k);
    end
  endtask

  task automatic test_idle_start_abort();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL idle_done_before: got %b expected 1", done); end
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0) begin
      errors++; $display("FAIL idle_start_abort: got done=%b busy=%b ready=%b expected 0 0 0", done, busy, word_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || word_ready !== 1'b0) begin
      errors++; $display("FAIL idle_stays: got busy=%b ready=%b expected 0 0", busy, word_ready);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_partial_word();
    test_backpressure();
    test_abort_and_start_busy();
    test_reset_mid_load();
    test_idle_start_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/config_loader.md
# config_loader

Serial configuration loader for the `fpga_250` fabric. It accepts configuration words from an upstream source over a valid/ready handshake and shifts them LSB-first onto the fabric's single-bit configuration chain, asserting a qualifying enable. It sits between the chip-level configuration source and `config_in`. It counts the total chain length, so the fabric is loaded with exactly `CHAIN_LEN` bits per `start`.

## Interface
- `WORD_W`, 32: width of each configuration word.
- `CHAIN_LEN`, 1024: total configuration bits in the fabric chain, ≥1.
- `CNT_W`, `$clog2(CHAIN_LEN+1)`: width of the bit counter (derived).

Ports:
- `clk`  in  1  single clock; every register is clocked on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE.
- `abort`  in  1  cancels a load in progress.
- `word_data`  in  `WORD_W`  configuration word; bit 0 is shifted first.
- `word_valid`  in  1  `word_data` is valid.
- `word_ready`  out  1  loader accepts a word this cycle.
- `cfg_bit`  out  1  serial data to the fabric `config_in`.
- `cfg_en`  out  1  `cfg_bit` is valid; the fabric chain shifts on this cycle.
- `busy`  out  1  high in LOAD and SHIFT.
- `done`  out  1  full chain loaded; held until the next accepted `start`, `abort` or `rst`.

## Operation
- States: IDLE, LOAD, SHIFT.
- **IDLE**
  - `start && !abort` → LOAD.
  - On that transition: clear `done` and set `bits_left` to `CHAIN_LEN`.
- **LOAD**
  - `word_ready`=1.
  - On `word_valid && word_ready`: capture `word_data` into the shift register, set `word_left` = min(`WORD_W`, `bits_left`), then → SHIFT.
- **SHIFT**
  - Each cycle: `cfg_en`=1 and `cfg_bit`=`shreg[0]`.
  - Each cycle: shift the register right, and decrement both `bits_left` and `word_left`.
- **End of a word** (the cycle where `word_left`==1):
  - If `bits_left`==1, this is the final bit: → IDLE and set `done`=1 on the next cycle.
  - Otherwise `word_ready`=1 in this same cycle. If a word is accepted, reload the register and stay in SHIFT with no bubble; if not, → LOAD.
- **Partial last word:** when `CHAIN_LEN` mod `WORD_W` ≠ 0, only the low remaining bits of the last word are shifted; its upper bits are discarded.
- **Start while busy:** `start` in LOAD or SHIFT is ignored.
- **Abort:**
  - `abort` in LOAD or SHIFT → IDLE next cycle, with `cfg_en`=0 from that cycle and `done` stays 0.
  - A word offered in the abort cycle is not accepted (`word_ready` is forced to 0).
- **Abort in IDLE:** `abort` clears `done`, and `start` in the same cycle is ignored.
- **Reset:** `rst` takes priority over everything. State=IDLE and all outputs (`word_ready`, `cfg_bit`, `cfg_en`, `busy`, `done`) = 0. Fabric chain contents are undefined after a mid-load reset.

## Timing
- `word_ready`, `cfg_en` and `cfg_bit` are decoded from registered state, with no combinational path from `word_valid`.
- `start` accepted at cycle t gives LOAD at t+1.
- If a word is accepted at cycle t, its first bit appears on `cfg_bit` with `cfg_en`=1 at t+1.
- With `word_valid` held high from t+1, the first bit appears at t+2 and the last bit at t+1+`CHAIN_LEN`.
- In that case `done` rises at t+2+`CHAIN_LEN` and the `cfg_en` pulses are contiguous.
- `cfg_en` is asserted for exactly `CHAIN_LEN` cycles per completed load.
- `busy` is high from t+1 until the last `cfg_en` cycle, inclusive.

## Structure
- The shared package `config_pkg` holds:
  - state encodings `ST_IDLE`=2'd0, `ST_LOAD`=2'd1, `ST_SHIFT`=2'd2;
  - the default `WORD_W`/`CHAIN_LEN` constants used by `fpga_250`.
- One sub-module, `cfg_piso`, a parallel-load serial-out shift register with `load`, `shift` and `d[WORD_W-1:0]` inputs and a `q0` output.
- The FSM and both counters stay in `config_loader`.

## Test plan
All scenarios use `WORD_W`=8 and `CHAIN_LEN`=20.
- **Streaming:** `start`, then words 0xA5, 0x3C, 0xFF with `word_valid` always high → `cfg_bit` sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,1.
  - `cfg_en` is high for 20 contiguous cycles, and `done` rises on the cycle after the last bit.
- **Partial last word:** as streaming, but the third word is 0x0F → only 4 bits are shifted in the last word (1,1,1,1) and its high nibble never appears.
- **Backpressure:** `word_valid` is dropped for 3 cycles between words 1 and 2 → `cfg_en` gaps for exactly 4 cycles (3 idle plus the LOAD handshake cycle), and the bit order is unchanged.
- **Abort and start-while-busy:** `abort` on the 5th SHIFT cycle → `cfg_en`=0 and `busy`=0 from the next cycle, and `done`=0.
  - A `start` asserted during SHIFT in an earlier run is ignored, and the loaded bit count stays 20.
- **Reset mid-load:** `rst` during SHIFT → next cycle all outputs are 0 and state is IDLE.
  - A new `start` then performs a complete 20-bit load.
- **Simultaneous events in IDLE:** `start`+`abort` in the same cycle → remains IDLE, and `word_ready` stays 0.
